// File: rtl/popcount23_tnn_seq.sv
// rtl/popcount23_tnn_seq.sv - ternary neuron sequencer time-sharing one 23-input popcount unit
module popcount23_tnn_seq #(
   parameter int CHUNKS = 4,
   parameter int ACC_W  = $clog2(31*CHUNKS+1)+1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [23*CHUNKS-1:0]     x_in,
   input  logic [23*CHUNKS-1:0]     wpos_in,
   input  logic [23*CHUNKS-1:0]     wneg_in,
   input  logic signed [ACC_W-1:0]  th_hi,
   input  logic signed [ACC_W-1:0]  th_lo,
   output logic [22:0]              pc_in,
   input  logic [4:0]               pc_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [1:0]               res_trit,
   output logic signed [ACC_W-1:0]  res_sum
);

   localparam int N   = 23*CHUNKS;
   localparam int C_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [C_W-1:0] C_LAST = C_W'(CHUNKS-1);

   typedef enum logic [1:0] {IDLE, POS, NEG, DONE} state_t;

   state_t                   state;
   state_t                   state_nx;
   logic [C_W-1:0]           c;
   logic signed [ACC_W-1:0]  acc;
   logic [N-1:0]             x_r;
   logic [N-1:0]             wpos_r;
   logic [N-1:0]             wneg_r;
   logic signed [ACC_W-1:0]  th_hi_r;
   logic signed [ACC_W-1:0]  th_lo_r;

   logic [22:0]              x_sl;
   logic [22:0]              wpos_sl;
   logic [22:0]              wneg_sl;
   logic signed [ACC_W-1:0]  pc_ext;
   logic signed [ACC_W-1:0]  acc_pos;
   logic signed [ACC_W-1:0]  acc_neg;
   logic [1:0]               trit_nx;
   logic                     start_fire;
   logic                     last_slice;

   // Select the latched operand slice addressed by the slice counter.
   always_comb begin
      x_sl    = '0;
      wpos_sl = '0;
      wneg_sl = '0;
      for (int k = 0; k < CHUNKS; k++) begin
         if (c == C_W'(k)) begin
            x_sl    = x_r[k*23 +: 23];
            wpos_sl = wpos_r[k*23 +: 23];
            wneg_sl = wneg_r[k*23 +: 23];
         end
      end
   end

   assign pc_ext     = {{(ACC_W-5){1'b0}}, pc_out};
   assign acc_pos    = acc + pc_ext;
   assign acc_neg    = acc - pc_ext;
   assign last_slice = (c == C_LAST);
   assign start_fire = (state == IDLE) && start_valid;

   // Ternary decision on the final sum; +1 wins when the thresholds overlap.
   always_comb begin
      trit_nx = 2'b00;
      if (acc_neg >= th_hi_r)
         trit_nx = 2'b01;
      else if (acc_neg <= th_lo_r)
         trit_nx = 2'b11;
   end

   // Next-state and state-decoded outputs; pc_in stays 0 outside POS/NEG to keep the shared unit quiet.
   always_comb begin
      state_nx    = state;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      pc_in       = '0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid)
               state_nx = POS;
         end
         POS: begin
            pc_in    = x_sl & wpos_sl;
            state_nx = NEG;
         end
         NEG: begin
            pc_in    = x_sl & wneg_sl;
            state_nx = last_slice ? DONE : POS;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Operand capture, slice counter and running accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c       <= '0;
         acc     <= '0;
         x_r     <= '0;
         wpos_r  <= '0;
         wneg_r  <= '0;
         th_hi_r <= '0;
         th_lo_r <= '0;
      end else begin
         if (start_fire) begin
            x_r     <= x_in;
            wpos_r  <= wpos_in;
            wneg_r  <= wneg_in;
            th_hi_r <= th_hi;
            th_lo_r <= th_lo;
            acc     <= '0;
            c       <= '0;
         end else if (state == POS) begin
            acc <= acc_pos;
         end else if (state == NEG) begin
            acc <= acc_neg;
            if (!last_slice)
               c <= c + 1'b1;
         end
      end
   end

   // Result registers, loaded only on the NEG to DONE transition and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_sum  <= '0;
         res_trit <= 2'b00;
      end else if ((state == NEG) && last_slice) begin
         res_sum  <= acc_neg;
         res_trit <= trit_nx;
      end
   end

endmodule

// File: tb/tb_popcount23_tnn_seq.sv
// tb/tb_popcount23_tnn_seq.sv - scoreboard bench for popcount23_tnn_seq
module tb_popcount23_tnn_seq;

   localparam int CHUNKS = 4;
   localparam int ACC_W  = 8;
   localparam int N      = 23*CHUNKS;

   typedef struct {
      int         sum;
      logic [1:0] trit;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    start_valid;
   logic                    start_ready;
   logic [N-1:0]            x_in;
   logic [N-1:0]            wpos_in;
   logic [N-1:0]            wneg_in;
   logic signed [ACC_W-1:0] th_hi;
   logic signed [ACC_W-1:0] th_lo;
   logic [22:0]             pc_in;
   logic [4:0]              pc_out;
   logic                    res_valid;
   logic                    res_ready;
   logic [1:0]              res_trit;
   logic signed [ACC_W-1:0] res_sum;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   mode  = 0;
   exp_t sb[$];
   exp_t mon_e;

   popcount23_tnn_seq #(.CHUNKS(CHUNKS)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .x_in(x_in), .wpos_in(wpos_in), .wneg_in(wneg_in), .th_hi(th_hi), .th_lo(th_lo),
      .pc_in(pc_in), .pc_out(pc_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_trit(res_trit), .res_sum(res_sum)
   );

   always #5 clk = ~clk;

   // Popcount unit stand-in: 0 exact, 1 approximate (+1), 2 saturated 31 for any nonzero operand.
   function automatic int pcf(logic [22:0] v);
      int n;
      n = $countones(v);
      case (mode)
         1: return n + 1;
         2: return (v != 0) ? 31 : 0;
         default: return n;
      endcase
   endfunction

   always_comb pc_out = 5'(pcf(pc_in));

   function automatic logic [22:0] slice(logic [N-1:0] x, logic [N-1:0] w, int c);
      return x[c*23 +: 23] & w[c*23 +: 23];
   endfunction

   function automatic exp_t model(logic [N-1:0] x, logic [N-1:0] wp, logic [N-1:0] wn, int hi, int lo);
      exp_t e;
      int   s;
      s = 0;
      for (int c = 0; c < CHUNKS; c++)
         s += pcf(slice(x, wp, c)) - pcf(slice(x, wn, c));
      e.sum  = s;
      e.trit = (s >= hi) ? 2'b01 : ((s <= lo) ? 2'b11 : 2'b00);
      return e;
   endfunction

   function automatic logic [N-1:0] rnd_vec();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[N-1:0];
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop and compare whenever a result handshake is about to happen.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("res_sum", int'(res_sum), mon_e.sum);
            check("res_trit", int'(res_trit), int'(mon_e.trit));
         end
      end
   end

   task automatic set_ops(logic [N-1:0] x, logic [N-1:0] wp, logic [N-1:0] wn, int hi, int lo);
      x_in    = x;
      wpos_in = wp;
      wneg_in = wn;
      th_hi   = ACC_W'(hi);
      th_lo   = ACC_W'(lo);
   endtask

   task automatic wait_ready();
      int b;
      b = 0;
      while (!start_ready && b < 200) begin
         @(posedge clk); #1;
         b++;
      end
      if (!start_ready) check("start_ready_timeout", 0, 1);
   endtask

   // Handshake at the next edge; leaves time at #1 after the handshake edge (cycle t, slice 0 POS).
   task automatic handshake(logic [N-1:0] x, logic [N-1:0] wp, logic [N-1:0] wn, int hi, int lo);
      set_ops(x, wp, wn, hi, lo);
      start_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      sb.push_back(model(x, wp, wn, hi, lo));
      #1;
      start_valid = 1'b0;
      set_ops(rnd_vec(), rnd_vec(), rnd_vec(), 0, 0);
   endtask

   // Full operation with pc_in sequence and latency checks; res_ready assumed high.
   task automatic run_dir(logic [N-1:0] x, logic [N-1:0] wp, logic [N-1:0] wn, int hi, int lo);
      handshake(x, wp, wn, hi, lo);
      for (int k = 0; k < 2*CHUNKS; k++) begin
         check("pc_in_seq", int'(pc_in), int'((k % 2 == 0) ? slice(x, wp, k/2) : slice(x, wn, k/2)));
         if (k < 2*CHUNKS-1) begin
            @(posedge clk); #1;
         end
      end
      check("res_valid_early", int'(res_valid), 0);
      @(posedge clk); #1;
      check("res_valid_latency", int'(res_valid), 1);
      check("pc_in_done", int'(pc_in), 0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 500) begin
         @(posedge clk); #1;
         b++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      logic [N-1:0] ones, x4, w4p, w4n, rx, rp, rn;
      exp_t         e;
      time          t_prev, t_now;
      int           hi, lo;

      ones = '1;
      x4   = (N'(7) << 23) | N'(5'h1F);
      w4p  = N'(5'h1F);
      w4n  = N'(7) << 23;

      rst_n       = 1'b0;
      start_valid = 1'b0;
      res_ready   = 1'b1;
      set_ops('0, '0, '0, 0, 0);
      #1;
      check("rst_start_ready", int'(start_ready), 1);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_res_trit", int'(res_trit), 0);
      check("rst_res_sum", int'(res_sum), 0);
      check("rst_pc_in", int'(pc_in), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset during NEG of slice 2.
      rx = rnd_vec(); rp = rnd_vec(); rn = rnd_vec();
      handshake(rx, rp, rn, 5, -5);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("pc_in_neg2", int'(pc_in), int'(slice(rx, rn, 2)));
      rst_n = 1'b0;
      #1;
      check("midrst_res_valid", int'(res_valid), 0);
      check("midrst_pc_in", int'(pc_in), 0);
      check("midrst_start_ready", int'(start_ready), 1);
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      run_dir(rx, rp, rn, 5, -5);

      // All-positive, all-negative, mid band and boundaries.
      run_dir(ones, ones, '0, 10, -10);
      run_dir(ones, '0, ones, 10, -10);
      run_dir(x4, w4p, w4n, 3, -3);
      run_dir(x4, w4p, w4n, 2, -3);
      run_dir(x4, w4p, w4n, 5, 2);
      run_dir(ones, ones, ones, -1, 4);

      // Backpressure in DONE with start_valid pulsing.
      res_ready = 1'b0;
      rx = rnd_vec(); rp = rnd_vec(); rn = rnd_vec();
      e = model(rx, rp, rn, 3, -3);
      handshake(rx, rp, rn, 3, -3);
      repeat (2*CHUNKS) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < 5; k++) begin
         start_valid = (k % 2 == 0);
         check("bp_res_valid", int'(res_valid), 1);
         check("bp_start_ready", int'(start_ready), 0);
         check("bp_res_sum", int'(res_sum), e.sum);
         check("bp_res_trit", int'(res_trit), int'(e.trit));
         @(posedge clk); #1;
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      check("bp_release_idle", int'(start_ready), 1);
      check("bp_release_valid", int'(res_valid), 0);
      check("bp_single_op", sb.size(), 0);

      // Back-to-back with the approximate unit; one operation every 10 cycles.
      mode        = 1;
      start_valid = 1'b1;
      t_prev      = 0;
      for (int i = 0; i < 6; i++) begin
         rx = rnd_vec(); rp = rnd_vec(); rn = rnd_vec();
         hi = int'($urandom_range(40)) - 20;
         lo = int'($urandom_range(40)) - 20;
         set_ops(rx, rp, rn, hi, lo);
         wait_ready();
         @(posedge clk);
         t_now = $time;
         sb.push_back(model(rx, rp, rn, hi, lo));
         if (i > 0) check("b2b_period", int'((t_now - t_prev) / 10), 2*CHUNKS+2);
         t_prev = t_now;
         #1;
      end
      start_valid = 1'b0;
      drain();

      // Saturated unit output: largest sum the accumulator must hold.
      mode = 2;
      run_dir(ones, ones, '0, 10, -10);
      drain();

      // Random operations with exact unit and random backpressure.
      mode = 0;
      for (int i = 0; i < 20; i++) begin
         hi = int'($urandom_range(60)) - 30;
         lo = int'($urandom_range(60)) - 30;
         handshake(rnd_vec(), rnd_vec(), rnd_vec(), hi, lo);
         for (int b = 0; b < 100 && sb.size() != 0; b++) begin
            res_ready = $urandom_range(1);
            @(posedge clk); #1;
         end
         res_ready = 1'b1;
         drain();
      end

      repeat (3) @(posedge clk);
      check("sb_empty_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/popcount23_tnn_seq.md
# popcount23_tnn_seq

Sequencing controller for a ternary neuron that time-shares one external 23-input popcount unit (exact or approximate `popcount23_*`) across `CHUNKS` 23-bit slices.
- Each operation computes S = Σ popcount(x & wpos) − Σ popcount(x & wneg) over all slices, accumulated in a signed register.
- S is then compared against two thresholds to produce a ternary output {−1, 0, +1}.
- The block sits between the layer input/weight registers and the neuron output stage.

## Interface
Parameters:
- `CHUNKS`, 4: number of 23-bit slices; neuron fan-in = 23*CHUNKS.
- `ACC_W`, `$clog2(31*CHUNKS+1)+1` (8 for CHUNKS=4): signed accumulator width; covers the 5-bit approximate output max of 31 per slice.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  operand set offered.
- `start_ready`  out  1  high only in IDLE.
- `x_in`  in  23*CHUNKS  binary activations; slice c = bits [23c+22:23c].
- `wpos_in`  in  23*CHUNKS  +1 weight mask.
- `wneg_in`  in  23*CHUNKS  −1 weight mask.
- `th_hi`  in  ACC_W  signed upper threshold.
- `th_lo`  in  ACC_W  signed lower threshold.
- `pc_in`  out  23  operand to the popcount unit.
- `pc_out`  in  5  combinational popcount result for the current `pc_in`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_trit`  out  2  ternary result: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0.
- `res_sum`  out  ACC_W  signed final S.

## Operation
- **FSM states:** IDLE, POS, NEG, DONE. Slice counter `c` is `$clog2(CHUNKS)` bits wide (minimum 1). Accumulator `acc` is ACC_W bits, signed.
- **IDLE:**
  - `start_ready`=1, `pc_in`=0.
  - On `start_valid`&`start_ready`, latch x/wpos/wneg/th_hi/th_lo, clear `acc` and `c`, then go to POS.
- **POS:** `pc_in` = x[c] & wpos[c]; `acc` += zero-extended `pc_out`; next state NEG.
- **NEG:** `pc_in` = x[c] & wneg[c]; `acc` −= zero-extended `pc_out`.
  - If c == CHUNKS−1: go to DONE.
  - Otherwise: c++ and go to POS.
- **Result registers:** on the NEG→DONE transition, register `res_sum` = final acc (acc − pc_out) and compute `res_trit` from it:
  - S ≥ th_hi → +1.
  - else S ≤ th_lo → −1.
  - else 0.
  - If th_lo ≥ th_hi, +1 takes priority; no error is flagged.
- **DONE:**
  - `res_valid`=1, `pc_in`=0, `start_ready`=0.
  - On `res_valid`&`res_ready`, go to IDLE.
  - `res_sum` and `res_trit` hold their values until the next NEG→DONE transition.
- **Idle operand:** `pc_in` is forced to 0 outside POS/NEG. This minimizes switching in the shared unit (printed-PDK power).
- **Input stability:** operands are used only from the latched copies; inputs may change freely after the start handshake.
- **`start_valid` outside IDLE:** ignored; no queuing.
- **Arithmetic:** two's-complement; no saturation needed, since ACC_W covers ±31*CHUNKS.

## Timing
- **Reset values:**
  - state IDLE, acc 0, c 0.
  - `start_ready` 1 (state-decoded, also during reset).
  - `res_valid` 0, `res_trit` 2'b00, `res_sum` 0, `pc_in` 0.
- **Reset mid-operation:** immediate return to IDLE with all of the above values; the partial result is discarded.
- **Latency:** start handshake at edge t → `res_valid` high after edge t+2*CHUNKS. `pc_in` shows slice c POS in cycle t+2c and NEG in cycle t+2c+1.
- **Throughput with `res_ready` tied high:** one operation per 2*CHUNKS+2 cycles (DONE 1 cycle, IDLE 1 cycle).
- **Combinational paths:** `pc_out` is sampled in the same cycle `pc_in` is driven; the path pc_in→pc_out→acc is single-cycle. No combinational path from any input to `start_ready`/`res_valid`.
- **Backpressure:** `res_ready` low holds DONE indefinitely, with all outputs stable.

## Test plan
Use an exact popcount model on `pc_out`, CHUNKS=4 unless noted.
1. **Reset mid-run:** assert `rst_n` low during NEG of slice 2 → same cycle `res_valid`=0, `pc_in`=0, `start_ready`=1; after release, a new start completes normally with correct S.
2. **All-positive:** x=all ones, wpos=all ones, wneg=0, th_hi=10, th_lo=−10 → `res_sum`=92, `res_trit`=01, `res_valid` rises exactly 8 cycles after the start handshake; `pc_in` sequence is 0x7FFFFF,0,0x7FFFFF,0,…
3. **All-negative:** x=all ones, wpos=0, wneg=all ones, same thresholds → `res_sum`=−92 (8'hA4), `res_trit`=11.
4. **Mid band and boundaries:**
   - x bits 0..4 of slice 0 set with wpos, and bits 0..2 of slice 1 set with wneg → S=2. th_hi=3, th_lo=−3 → 00.
   - Rerun with th_hi=2 → 01.
   - Rerun with th_lo=2, th_hi=5 → 11.
5. **Backpressure:** hold `res_ready`=0 for 5 cycles in DONE while pulsing `start_valid` → `res_valid` stays 1, `res_sum`/`res_trit` stable, `start_ready`=0, no new operation starts; `res_ready`=1 → IDLE next edge.
6. **Back-to-back with approximate model:** substitute a `pc_out` stub returning popcount+1 (max 24), `res_ready`=1, `start_valid` held high → operations complete every 10 cycles, each S offset by +4−4=0 versus exact, and `acc` never overflows with `pc_out`=31 forced (S=124).
